// File: rtl/brick_game_sequencer_if.sv
// Engine-side signal bundle between the brick game sequencer and the ball/paddle engine.
// Strobes are single-CLK pulses; miss and bricks_left are levels sampled on qualifying ticks.
interface brick_game_sequencer_if;
    logic       miss;
    logic [4:0] bricks_left;
    logic       ball_step;
    logic       round_reset;
    logic       board_reset;
    logic       hands_on;

    modport master (
        output ball_step, round_reset, board_reset, hands_on,
        input  miss, bricks_left
    );

    modport slave (
        input  ball_step, round_reset, board_reset, hands_on,
        output miss, bricks_left
    );
endinterface

// File: rtl/brick_game_sequencer.sv
// Round/level controller for the 8x8 LED brick-breaker: phases, lives, level and ball speed.
// Everything advances only on CLK edges where tick and start are both high.
module brick_game_sequencer #(
    parameter int BALL_DIV_INIT = 3,
    parameter int BALL_DIV_MIN  = 1,
    parameter int LEVELS        = 4,
    parameter int LOST_HOLD     = 10,
    parameter int CLEAR_HOLD    = 20
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          restart,
    input  logic                          serve,
    brick_game_sequencer_if.master        eng,
    output logic [2:0]                    state,
    output logic [2:0]                    life,
    output logic [1:0]                    level,
    output logic                          game_over,
    output logic                          win
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        CLEAR = 3'd4,
        OVER  = 3'd5
    } phase_t;

    localparam logic [1:0] LAST_LEVEL = 2'(LEVELS - 1);
    localparam logic [7:0] LOST_LAST  = 8'(LOST_HOLD - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_HOLD - 1);
    localparam logic [2:0] DIV_INIT   = 3'(BALL_DIV_INIT);
    localparam logic [2:0] DIV_MIN    = 3'(BALL_DIV_MIN);

    phase_t     state_q, state_d;
    logic       hands_q, hands_d;
    logic [2:0] life_q, life_d;
    logic [1:0] level_q, level_d;
    logic [2:0] step_q, step_d;
    logic [7:0] hold_q, hold_d;
    logic       ball_step_q, ball_step_d;
    logic       round_q, round_d;
    logic       board_q, board_d;
    logic       over_q, over_d;
    logic       win_q, win_d;
    logic       advance;
    logic [2:0] level_ext;
    logic [2:0] div_raw;
    logic [2:0] div;

    assign advance = tick & start;

    // Ticks per ball step; the subtraction is clamped at zero before the floor is applied.
    always_comb begin
        level_ext = {1'b0, level_q};
        div_raw   = (DIV_INIT > level_ext) ? (DIV_INIT - level_ext) : 3'd0;
        div       = (div_raw > DIV_MIN) ? div_raw : DIV_MIN;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hands_q     <= 1'b1;
            life_q      <= 3'b111;
            level_q     <= 2'd0;
            step_q      <= 3'd0;
            hold_q      <= 8'd0;
            ball_step_q <= 1'b0;
            round_q     <= 1'b0;
            board_q     <= 1'b0;
            over_q      <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hands_q     <= hands_d;
            life_q      <= life_d;
            level_q     <= level_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            ball_step_q <= ball_step_d;
            round_q     <= round_d;
            board_q     <= board_d;
            over_q      <= over_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hands_d     = hands_q;
        life_d      = life_q;
        level_d     = level_q;
        step_d      = step_q;
        hold_d      = hold_q;
        over_d      = over_q;
        win_d       = win_q;
        ball_step_d = 1'b0;
        round_d     = 1'b0;
        board_d     = 1'b0;
        if (advance) begin
            case (state_q)
                IDLE: begin
                    state_d = SERVE;
                    hands_d = 1'b1;
                    board_d = 1'b1;
                    round_d = 1'b1;
                end
                SERVE: begin
                    hands_d = 1'b1;
                    if (restart) begin
                        round_d = 1'b1;
                    end else if (serve) begin
                        state_d = PLAY;
                        hands_d = 1'b0;
                        step_d  = 3'd0;
                    end
                end
                PLAY: begin
                    // Board clear outranks a miss on the same tick.
                    if (eng.bricks_left == 5'd0) begin
                        state_d = CLEAR;
                        hold_d  = 8'd0;
                    end else if (eng.miss) begin
                        life_d  = {life_q[1:0], 1'b0};
                        hands_d = 1'b1;
                        hold_d  = 8'd0;
                        if (life_q[1:0] == 2'b00) begin
                            state_d = OVER;
                            over_d  = 1'b1;
                        end else begin
                            state_d = LOST;
                        end
                    end else if (restart) begin
                        state_d = SERVE;
                        hands_d = 1'b1;
                        round_d = 1'b1;
                    end else if (step_q == div - 3'd1) begin
                        ball_step_d = 1'b1;
                        step_d      = 3'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                LOST: begin
                    if (restart || hold_q == LOST_LAST) begin
                        state_d = SERVE;
                        hands_d = 1'b1;
                        round_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                CLEAR: begin
                    if (hold_q == CLEAR_LAST) begin
                        if (level_q < LAST_LEVEL) begin
                            level_d = level_q + 2'd1;
                            state_d = SERVE;
                            hands_d = 1'b1;
                            board_d = 1'b1;
                            round_d = 1'b1;
                        end else begin
                            state_d = OVER;
                            win_d   = 1'b1;
                            over_d  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                OVER: begin
                    if (restart) begin
                        state_d = SERVE;
                        hands_d = 1'b1;
                        life_d  = 3'b111;
                        level_d = 2'd0;
                        win_d   = 1'b0;
                        over_d  = 1'b0;
                        board_d = 1'b1;
                        round_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign state           = state_q;
    assign life            = life_q;
    assign level           = level_q;
    assign game_over       = over_q;
    assign win             = win_q;
    assign eng.hands_on    = hands_q;
    assign eng.ball_step   = ball_step_q;
    assign eng.round_reset = round_q;
    assign eng.board_reset = board_q;

endmodule

// File: tb/tb_brick_game_sequencer.sv
// Bench for brick_game_sequencer: directed game scenarios then random play, all checked
// against a lives/level/tick-count model of the game rules.
module tb_brick_game_sequencer;

    localparam int BALL_DIV_INIT = 3;
    localparam int BALL_DIV_MIN  = 1;
    localparam int LEVELS        = 4;
    localparam int LOST_HOLD     = 10;
    localparam int CLEAR_HOLD    = 20;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_LOST  = 3;
    localparam int S_CLEAR = 4;
    localparam int S_OVER  = 5;

    logic       CLK = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       restart;
    logic       serve;
    logic [2:0] state;
    logic [2:0] life;
    logic [1:0] level;
    logic       game_over;
    logic       win;

    brick_game_sequencer_if eng();

    brick_game_sequencer #(
        .BALL_DIV_INIT (BALL_DIV_INIT),
        .BALL_DIV_MIN  (BALL_DIV_MIN),
        .LEVELS        (LEVELS),
        .LOST_HOLD     (LOST_HOLD),
        .CLEAR_HOLD    (CLEAR_HOLD)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .restart   (restart),
        .serve     (serve),
        .eng       (eng),
        .state     (state),
        .life      (life),
        .level     (level),
        .game_over (game_over),
        .win       (win)
    );

    // Clock and time-limit guard
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "time limit");
    end

    // Scoreboard: {state,hands_on,life,level,game_over,win,ball_step,round_reset,board_reset}
    logic [13:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model of the game rules
    int m_state, m_lives, m_level, m_play_ticks, m_hold_ticks;
    bit m_hands, m_over, m_win;

    function automatic logic [2:0] therm(input int n);
        case (n)
            3:       return 3'b111;
            2:       return 3'b110;
            1:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int cur_div();
        int d;
        d = BALL_DIV_INIT - m_level;
        if (d < BALL_DIV_MIN) d = BALL_DIV_MIN;
        return d;
    endfunction

    task automatic push_expected(input bit e_step, input bit e_round, input bit e_board);
        exp_q.push_back({3'(m_state), m_hands, therm(m_lives), 2'(m_level), m_over, m_win,
                         e_step, e_round, e_board});
    endtask

    task automatic model_reset();
        m_state      = S_IDLE;
        m_lives      = 3;
        m_level      = 0;
        m_play_ticks = 0;
        m_hold_ticks = 0;
        m_hands      = 1'b1;
        m_over       = 1'b0;
        m_win        = 1'b0;
    endtask

    task automatic model_tick(input bit st, input bit rs, input bit sv, input bit ms,
                              input int bl);
        bit e_step, e_round, e_board;
        e_step = 0; e_round = 0; e_board = 0;
        if (st) begin
            case (m_state)
                S_IDLE: begin
                    m_state = S_SERVE; e_round = 1; e_board = 1;
                end
                S_SERVE: begin
                    if (rs) e_round = 1;
                    else if (sv) begin
                        m_state = S_PLAY; m_hands = 0; m_play_ticks = 0;
                    end
                end
                S_PLAY: begin
                    if (bl == 0) begin
                        m_state = S_CLEAR; m_hold_ticks = 0;
                    end else if (ms) begin
                        m_lives      = m_lives - 1;
                        m_hands      = 1;
                        m_hold_ticks = 0;
                        if (m_lives == 0) begin
                            m_state = S_OVER; m_over = 1;
                        end else m_state = S_LOST;
                    end else if (rs) begin
                        m_state = S_SERVE; m_hands = 1; e_round = 1;
                    end else begin
                        m_play_ticks = m_play_ticks + 1;
                        if (m_play_ticks % cur_div() == 0) e_step = 1;
                    end
                end
                S_LOST: begin
                    m_hold_ticks = m_hold_ticks + 1;
                    if (rs || m_hold_ticks == LOST_HOLD) begin
                        m_state = S_SERVE; e_round = 1;
                    end
                end
                S_CLEAR: begin
                    m_hold_ticks = m_hold_ticks + 1;
                    if (m_hold_ticks == CLEAR_HOLD) begin
                        if (m_level < LEVELS - 1) begin
                            m_level = m_level + 1; m_state = S_SERVE; m_hands = 1;
                            e_round = 1; e_board = 1;
                        end else begin
                            m_state = S_OVER; m_win = 1; m_over = 1;
                        end
                    end
                end
                S_OVER: begin
                    if (rs) begin
                        m_state = S_SERVE; m_hands = 1; m_lives = 3; m_level = 0;
                        m_win = 0; m_over = 0; e_round = 1; e_board = 1;
                    end
                end
                default: ;
            endcase
        end
        push_expected(e_step, e_round, e_board);
    endtask

    task automatic chk(input string tag, input string field, input logic [7:0] obs,
                       input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h t=%0t", tag, field, obs, expv, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        chk(tag, "state",       {5'd0, state},           {5'd0, e[13:11]});
        chk(tag, "hands_on",    {7'd0, eng.hands_on},    {7'd0, e[10]});
        chk(tag, "life",        {5'd0, life},            {5'd0, e[9:7]});
        chk(tag, "level",       {6'd0, level},           {6'd0, e[6:5]});
        chk(tag, "game_over",   {7'd0, game_over},       {7'd0, e[4]});
        chk(tag, "win",         {7'd0, win},             {7'd0, e[3]});
        chk(tag, "ball_step",   {7'd0, eng.ball_step},   {7'd0, e[2]});
        chk(tag, "round_reset", {7'd0, eng.round_reset}, {7'd0, e[1]});
        chk(tag, "board_reset", {7'd0, eng.board_reset}, {7'd0, e[0]});
    endtask

    // Driver: one qualifying-or-not tick, then quiet cycles with noise on the other inputs.
    task automatic do_tick(input string tag, input bit st, input bit rs, input bit sv,
                           input bit ms, input int bl, input int gap);
        start           = st;
        restart         = rs;
        serve           = sv;
        eng.miss        = ms;
        eng.bricks_left = 5'(bl);
        tick            = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
        model_tick(st, rs, sv, ms, bl);
        check_outputs(tag);
        for (int g = 0; g <= gap; g++) begin
            restart         = 1'($urandom_range(0, 1));
            serve           = 1'($urandom_range(0, 1));
            eng.miss        = 1'($urandom_range(0, 1));
            eng.bricks_left = 5'($urandom_range(0, 16));
            start           = 1'($urandom_range(0, 1));
            @(negedge CLK);
            push_expected(0, 0, 0);
            check_outputs({tag, "_quiet"});
        end
    endtask

    task automatic play_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) do_tick(tag, 1, 0, 0, 0, 16, 0);
    endtask

    task automatic hold_until_serve(input string tag, input int restart_at);
        int n;
        n = 0;
        while ((m_state == S_LOST || m_state == S_CLEAR) && n < 60) begin
            do_tick(tag, ($urandom_range(0, 4) != 0), (n == restart_at),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; restart = 1'b0; serve = 1'b0;
        eng.miss = 1'b0; eng.bricks_left = 5'd16;
        model_reset();
        repeat (2) @(negedge CLK);
        push_expected(0, 0, 0);
        check_outputs("reset");
        reset = 1'b0;
        @(negedge CLK);
        push_expected(0, 0, 0);
        check_outputs("reset_release");

        // Start-up: a tick without start is ignored, then IDLE->SERVE
        do_tick("idle_nostart", 0, 0, 0, 0, 16, 0);
        do_tick("idle_to_serve", 1, 0, 0, 0, 16, 0);
        do_tick("serve_wait", 1, 0, 0, 1, 16, 0);
        do_tick("serve_restart", 1, 1, 0, 0, 16, 0);

        // Level 0 ball steps every 3 ticks
        do_tick("serve_go", 1, 0, 1, 0, 16, 0);
        play_ticks("play_l0", 9);

        // Three misses down to OVER
        do_tick("miss1", 1, 0, 0, 1, 16, 0);
        hold_until_serve("lost1", 99);
        do_tick("serve2", 1, 0, 1, 0, 16, 0);
        play_ticks("play2", 2);
        do_tick("miss2", 1, 0, 0, 1, 16, 0);
        hold_until_serve("lost2", 4);
        do_tick("serve3", 1, 0, 1, 0, 16, 0);
        play_ticks("play3", 1);
        do_tick("miss3", 1, 0, 0, 1, 16, 0);
        do_tick("over_ignore", 1, 0, 1, 1, 16, 0);
        do_tick("over_restart", 1, 1, 0, 0, 16, 0);

        // Board clear outranks a miss; level 1 steps every 2 ticks
        do_tick("serve4", 1, 0, 1, 0, 16, 0);
        play_ticks("play4", 2);
        do_tick("clear_and_miss", 1, 0, 0, 1, 0, 0);
        hold_until_serve("clear0", 5);
        do_tick("serve_l1", 1, 0, 1, 0, 16, 0);
        play_ticks("play_l1", 6);

        // Clear the remaining levels to a win
        for (int lv = 1; lv < LEVELS; lv++) begin
            if (m_state == S_PLAY) do_tick("clear_lv", 1, 0, 0, 0, 0, 0);
            hold_until_serve("clear_hold", 3);
            if (m_state == S_SERVE) do_tick("serve_lv", 1, 0, 1, 0, 16, 0);
        end
        do_tick("won_idle", 1, 0, 1, 1, 16, 1);
        do_tick("won_restart", 1, 1, 0, 0, 16, 0);

        // start low freezes play
        do_tick("serve5", 1, 0, 1, 0, 16, 0);
        play_ticks("play5", 1);
        for (int i = 0; i < 50; i++)
            do_tick("frozen", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 16), 0);
        play_ticks("thaw", 4);

        // Asynchronous reset in the middle of a LOST hold
        do_tick("miss_lost", 1, 0, 0, 1, 16, 0);
        do_tick("lost_a", 1, 0, 0, 0, 16, 0);
        do_tick("lost_b", 0, 0, 0, 0, 16, 0);
        do_tick("lost_c", 1, 0, 0, 0, 16, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        push_expected(0, 0, 0);
        check_outputs("async_reset");
        @(negedge CLK);
        reset = 1'b0;

        // Random play
        for (int i = 0; i < 450; i++) begin
            do_tick("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
                    (($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 16)),
                    $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brick_game_sequencer.md
Name: brick_game_sequencer

Overview:
Round and level controller for the 8x8 LED brick-breaker game.
- Sequences the ball/paddle engine through idle, serve, play, life-lost pause, board-clear and game-over phases.
- Owns the life counter, level index and ball-speed schedule.
- Issues the reposition (round) and brick-restore (board) strobes to the engine.
- The engine reports misses and the remaining brick count back to it.
- The display scanner reads its life, game_over and win outputs.

Parameters:
BALL_DIV_INIT, 3, ticks per ball step at level 0
BALL_DIV_MIN, 1, floor for ticks per ball step
LEVELS, 4, number of levels; the game is won when level LEVELS-1 is cleared
LOST_HOLD, 10, ticks of pause after a life is lost
CLEAR_HOLD, 20, ticks of pause after the board is cleared

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
tick  in  1  one-CLK-cycle enable at button rate (20 Hz); all sequencing advances only on tick
start  in  1  run enable; when low, state, counters and pulses freeze
restart  in  1  game reset button, sampled on tick
serve  in  1  throw button, sampled on tick
miss  in  1  engine flag: ball passed the paddle row; sampled on tick
bricks_left  in  5  engine count of remaining bricks (0..16)
state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 LOST, 4 CLEAR, 5 OVER
hands_on  out  1  ball rides on the paddle
ball_step  out  1  one-CLK pulse: engine advances the ball one cell
round_reset  out  1  one-CLK pulse: recentre paddle and ball
board_reset  out  1  one-CLK pulse: restore all bricks
life  out  3  thermometer 111/110/100/000
level  out  2  current level index
game_over  out  1  high in OVER
win  out  1  high in OVER when the last level was cleared

Behaviour:
Reset values:
- state=IDLE, hands_on=1, life=3'b111, level=0.
- ball_step, round_reset, board_reset, game_over and win all 0.
- Step counter and hold counter both 0.

General rules:
- All transitions occur on a CLK edge where tick=1 and start=1. Otherwise registers hold and no pulses are emitted.
- Pulses are registered: asserted for exactly the one CLK cycle following the qualifying tick edge.
- Step divisor div = max(BALL_DIV_INIT - level, BALL_DIV_MIN), computed in 3 bits unsigned with no underflow. Defaults give div = 3, 2, 1, 1.

IDLE:
- Advances to SERVE on the first qualifying tick, pulsing board_reset and round_reset.

SERVE:
- hands_on=1.
- restart -> round_reset pulse; stay in SERVE.
- Otherwise serve -> PLAY, hands_on=0, step counter=0.
- miss is ignored.

PLAY:
- Evaluate in this priority order on each qualifying tick:
  1. bricks_left==0 -> CLEAR, hold counter=0.
  2. miss -> life <= {life[1:0],0}. If the new life is 000 -> OVER, else -> LOST. hands_on=1, hold counter=0.
  3. restart -> round_reset pulse, SERVE, life unchanged.
  4. Otherwise the step counter increments. When it reaches div-1: pulse ball_step and clear the counter. The first ball_step comes div ticks after the serve.
- No ball_step is issued on a tick that takes a transition.

LOST:
- Hold counter counts ticks.
- At LOST_HOLD-1: round_reset pulse, SERVE.
- restart shortcuts the hold the same way.

CLEAR:
- Hold counter counts CLEAR_HOLD ticks; restart and miss are ignored.
- At expiry, if level < LEVELS-1: level++, board_reset and round_reset pulses, SERVE.
- Otherwise: win=1, game_over=1, OVER.

OVER:
- game_over=1; life, level and win hold.
- restart -> life=111, level=0, win=0, game_over=0, board_reset and round_reset pulses, SERVE.
- serve and miss are ignored.

Boundary conditions:
- life never underflows: it shifts only from PLAY, and the 000 case always exits to OVER.
- level saturates at LEVELS-1.
- A mid-operation reset returns to the reset values immediately, without waiting for CLK or tick.
- start falling mid-hold pauses the hold counter and does not restart it.

Test Plan:
- Reset, then start=1 with 3 ticks -> IDLE->SERVE on tick 1 with board_reset and round_reset each high for exactly 1 CLK; hands_on=1; life=111.
- SERVE, serve on a tick, then 9 ticks at level 0 -> ball_step pulses after ticks 3, 6 and 9 (3 pulses); hands_on=0.
- PLAY, miss three times, each followed by a LOST hold -> life 110 (LOST, round_reset after 10 ticks) -> 100 -> 000; state=OVER, game_over=1, win=0. Then restart -> life=111, state=SERVE, board_reset pulse.
- PLAY with bricks_left=0 and miss=1 on the same tick -> CLEAR, life unchanged. After 20 ticks: level=1, SERVE. At level 1, ball_step occurs every 2 ticks.
- Clear levels 0..3 -> after the fourth CLEAR hold: state=OVER, win=1, game_over=1, level=3.
- PLAY with start=0 for 50 ticks -> no ball_step and counters frozen. Assert reset mid-LOST -> all outputs return to their reset values within the same cycle, before the next CLK edge.
